// File: rtl/motor_pwm_if.sv
// Command and H-bridge bundle between the drive FSM and the motor PWM driver.
// Commands are level signals sampled every clock; there is no valid/ready handshake.
interface motor_pwm_if;
    logic [2:0] drive_state;
    logic [1:0] speed;
    logic       enable;
    logic       motor_l_in1;
    logic       motor_l_in2;
    logic       motor_l_pwm;
    logic       motor_r_in1;
    logic       motor_r_in2;
    logic       motor_r_pwm;
    logic       braking;
    logic [1:0] state_l;
    logic [1:0] state_r;

    modport master (
        output drive_state, speed, enable,
        input  motor_l_in1, motor_l_in2, motor_l_pwm,
        input  motor_r_in1, motor_r_in2, motor_r_pwm,
        input  braking, state_l, state_r
    );

    modport slave (
        input  drive_state, speed, enable,
        output motor_l_in1, motor_l_in2, motor_l_pwm,
        output motor_r_in1, motor_r_in2, motor_r_pwm,
        output braking, state_l, state_r
    );
endinterface

// File: rtl/motor_pwm_driver.sv
// Two-motor H-bridge driver: per-motor IDLE/RUN/DEAD FSM, ramped duty, shared PWM counter.
// Motor index 0 is the left motor, index 1 the right; state_l/state_r expose the FSMs.
module motor_pwm_driver #(
    parameter int PWM_PERIOD  = 2500,
    parameter int DEAD_CYCLES = 50000,
    parameter int RAMP_STEP   = 25,
    parameter int DUTY_1      = 1000,
    parameter int DUTY_2      = 1750,
    parameter int DUTY_3      = 2500
) (
    input  logic        clk_50,
    input  logic        reset,
    motor_pwm_if.slave  ctrl
);
    localparam int CW = $clog2(PWM_PERIOD + 1);
    localparam int DW = $clog2(DEAD_CYCLES + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(PWM_PERIOD - 1);
    localparam logic [CW-1:0] DUTY_L1   = CW'(DUTY_1);
    localparam logic [CW-1:0] DUTY_L2   = CW'(DUTY_2);
    localparam logic [CW-1:0] DUTY_L3   = CW'(DUTY_3);
    localparam logic [CW:0]   RAMP_W    = (CW + 1)'(RAMP_STEP);
    localparam logic [CW-1:0] RAMP_N    = CW'(RAMP_STEP);
    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DEAD = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        REQ_OFF = 2'd0,
        REQ_FWD = 2'd1,
        REQ_REV = 2'd2
    } req_t;

    req_t          req [2];
    logic [CW-1:0] target;
    logic [CW-1:0] pwm_cnt;
    logic          boundary;
    logic [1:0]    in1_v;
    logic [1:0]    in2_v;
    logic [1:0]    pwm_v;
    logic [1:0]    dead_v;
    logic [1:0]    state_v [2];

    // Direction request per motor; invalid codes and enable=0 both mean off.
    always_comb begin
        req[0] = REQ_OFF;
        req[1] = REQ_OFF;
        if (ctrl.enable) begin
            case (ctrl.drive_state)
                3'd1: begin req[0] = REQ_FWD; req[1] = REQ_FWD; end
                3'd2: begin req[0] = REQ_REV; req[1] = REQ_REV; end
                3'd3: begin req[0] = REQ_REV; req[1] = REQ_FWD; end
                3'd4: begin req[0] = REQ_FWD; req[1] = REQ_REV; end
                default: ;
            endcase
        end
    end

    always_comb begin
        target = '0;
        case (ctrl.speed)
            2'd1:    target = DUTY_L1;
            2'd2:    target = DUTY_L2;
            2'd3:    target = DUTY_L3;
            default: target = '0;
        endcase
    end

    assign boundary = (pwm_cnt == CNT_LAST);

    always_ff @(posedge clk_50) begin
        if (reset) begin
            pwm_cnt <= '0;
        end else if (boundary) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + CW'(1);
        end
    end

    for (genvar m = 0; m < 2; m++) begin : g_motor
        state_t        state_q, state_d;
        logic [CW-1:0] duty_q, duty_d;
        logic          rev_q, rev_d;
        logic [DW-1:0] dead_q, dead_d;
        logic          pwm_q;
        logic [CW:0]   up_sum;
        logic [CW:0]   down_gap;
        logic [CW-1:0] ramped;
        logic          req_on;
        logic          req_rev;

        assign req_on  = (req[m] != REQ_OFF);
        assign req_rev = (req[m] == REQ_REV);

        // One step toward target, computed one bit wider so the sum cannot wrap.
        always_comb begin
            up_sum   = {1'b0, duty_q} + RAMP_W;
            down_gap = '0;
            ramped   = duty_q;
            if (duty_q < target) begin
                ramped = (up_sum >= {1'b0, target}) ? target : up_sum[CW-1:0];
            end else if (duty_q > target) begin
                down_gap = {1'b0, duty_q} - {1'b0, target};
                ramped   = (down_gap <= RAMP_W) ? target : (duty_q - RAMP_N);
            end
        end

        // Off has priority over reversal, reversal over a speed change.
        always_comb begin
            state_d = state_q;
            duty_d  = duty_q;
            rev_d   = rev_q;
            dead_d  = dead_q;
            case (state_q)
                S_IDLE: begin
                    duty_d = '0;
                    if (req_on) begin
                        state_d = S_RUN;
                        rev_d   = req_rev;
                    end
                end
                S_RUN: begin
                    if (!req_on) begin
                        state_d = S_IDLE;
                        duty_d  = '0;
                    end else if (req_rev != rev_q) begin
                        state_d = S_DEAD;
                        duty_d  = '0;
                        dead_d  = DEAD_LOAD;
                    end else if (boundary) begin
                        duty_d = ramped;
                    end
                end
                S_DEAD: begin
                    duty_d = '0;
                    if (dead_q == '0) begin
                        if (req_on) begin
                            state_d = S_RUN;
                            rev_d   = req_rev;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        dead_d = dead_q - DW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    duty_d  = '0;
                end
            endcase
        end

        always_ff @(posedge clk_50) begin
            if (reset) begin
                state_q <= S_IDLE;
                duty_q  <= '0;
                rev_q   <= 1'b0;
                dead_q  <= '0;
                pwm_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                duty_q  <= duty_d;
                rev_q   <= rev_d;
                dead_q  <= dead_d;
                pwm_q   <= (pwm_cnt < duty_q);
            end
        end

        // Gating with the state register drops EN in the same cycle the motor leaves RUN.
        assign in1_v[m]   = (state_q == S_RUN) && !rev_q;
        assign in2_v[m]   = (state_q == S_RUN) && rev_q;
        assign pwm_v[m]   = (state_q == S_RUN) && pwm_q;
        assign dead_v[m]  = (state_q == S_DEAD);
        assign state_v[m] = state_q;
    end

    assign ctrl.motor_l_in1 = in1_v[0];
    assign ctrl.motor_l_in2 = in2_v[0];
    assign ctrl.motor_l_pwm = pwm_v[0];
    assign ctrl.motor_r_in1 = in1_v[1];
    assign ctrl.motor_r_in2 = in2_v[1];
    assign ctrl.motor_r_pwm = pwm_v[1];
    assign ctrl.braking     = |dead_v;
    assign ctrl.state_l     = state_v[0];
    assign ctrl.state_r     = state_v[1];
endmodule

// File: tb/tb_motor_pwm_driver.sv
// Directed bench for motor_pwm_driver with small parameters (period 10, dead time 20, step 2).
// Windows of 10 samples are aligned to the bench's own cycle count since reset release.
module tb_motor_pwm_driver;
  localparam int P  = 10;
  localparam int DC = 20;

  logic clk_50 = 1'b0;
  logic reset  = 1'b1;

  motor_pwm_if ctrl();

  motor_pwm_driver #(
    .PWM_PERIOD (P),
    .DEAD_CYCLES(DC),
    .RAMP_STEP  (2),
    .DUTY_1     (4),
    .DUTY_2     (7),
    .DUTY_3     (10)
  ) dut (
    .clk_50(clk_50),
    .reset (reset),
    .ctrl  (ctrl)
  );

  // ---------------- clock ----------------
  always #5 clk_50 = ~clk_50;

  int checks = 0;
  int errors = 0;
  int ph     = 0;
  logic [31:0] exp_q[$];

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_50);
    @(negedge clk_50);
    ph++;
  endtask

  function automatic logic [6:0] all_out();
    return {ctrl.motor_l_in1, ctrl.motor_l_in2, ctrl.motor_l_pwm,
            ctrl.motor_r_in1, ctrl.motor_r_in2, ctrl.motor_r_pwm, ctrl.braking};
  endfunction

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      chk("reset_outputs", 32'(all_out()), 32'd0);
    end
    reset = 1'b0;
    ph = 0;
  endtask

  // Scoreboard: each window pops the expected high count for both motors.
  task automatic measure_window(input string tag);
    int hl;
    int hr;
    logic [31:0] e;
    while (ph % P != 0) step();
    hl = 0;
    hr = 0;
    for (int i = 0; i < P; i++) begin
      step();
      if (ctrl.motor_l_pwm === 1'b1) hl++;
      if (ctrl.motor_r_pwm === 1'b1) hr++;
    end
    e = exp_q.pop_front();
    chk({tag, "_l"}, 32'(hl), e);
    chk({tag, "_r"}, 32'(hr), e);
  endtask

  task automatic count_braking(input int n, input string tag);
    int hb;
    hb = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (ctrl.braking === 1'b1) hb++;
    end
    chk(tag, 32'(hb), 32'(n));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    ctrl.enable      = 1'b1;
    ctrl.drive_state = 3'd1;
    ctrl.speed       = 2'd3;

    // Reset with FWD/speed 3 pending, then ramp to full duty.
    do_reset(3);
    step();
    chk("start_l_in1", 32'(ctrl.motor_l_in1), 32'd1);
    chk("start_r_in1", 32'(ctrl.motor_r_in1), 32'd1);
    chk("start_l_in2", 32'(ctrl.motor_l_in2), 32'd0);
    chk("start_state_l", 32'(ctrl.state_l), 32'd1);
    exp_q = '{2, 4, 6, 8, 10, 10};
    for (int i = 0; i < 6; i++) measure_window("ramp_full");

    // FWD speed 2: ramp saturates exactly at 7.
    ctrl.speed = 2'd2;
    do_reset(2);
    exp_q = '{0, 2, 4, 6, 7, 7};
    for (int i = 0; i < 6; i++) measure_window("ramp_sat7");

    // Reverse at duty 7: dead-time then REV ramp from 2.
    ctrl.drive_state = 3'd2;
    step();
    chk("rev_braking", 32'(ctrl.braking), 32'd1);
    chk("rev_dead_dir", 32'({ctrl.motor_l_in1, ctrl.motor_l_in2}), 32'd0);
    chk("rev_dead_pwm", 32'(ctrl.motor_l_pwm), 32'd0);
    chk("rev_state_l", 32'(ctrl.state_l), 32'd2);
    count_braking(DC - 1, "rev_dead_len");
    step();
    chk("rev_end_braking", 32'(ctrl.braking), 32'd0);
    chk("rev_l_dir", 32'({ctrl.motor_l_in1, ctrl.motor_l_in2}), 32'd1);
    chk("rev_r_dir", 32'({ctrl.motor_r_in1, ctrl.motor_r_in2}), 32'd1);
    exp_q = '{2, 4};
    for (int i = 0; i < 2; i++) measure_window("rev_ramp");

    // RIGHT then LEFT: both motors reverse through DEAD.
    ctrl.speed       = 2'd1;
    ctrl.drive_state = 3'd4;
    do_reset(2);
    step();
    chk("right_l_dir", 32'({ctrl.motor_l_in1, ctrl.motor_l_in2}), 32'd2);
    chk("right_r_dir", 32'({ctrl.motor_r_in1, ctrl.motor_r_in2}), 32'd1);
    repeat (12) step();
    ctrl.drive_state = 3'd3;
    step();
    chk("left_state_l", 32'(ctrl.state_l), 32'd2);
    chk("left_state_r", 32'(ctrl.state_r), 32'd2);
    count_braking(DC - 1, "left_dead_len");
    step();
    chk("left_end_braking", 32'(ctrl.braking), 32'd0);
    chk("left_l_dir", 32'({ctrl.motor_l_in1, ctrl.motor_l_in2}), 32'd1);
    chk("left_r_dir", 32'({ctrl.motor_r_in1, ctrl.motor_r_in2}), 32'd2);

    // Invalid drive_state at full duty: immediate stop.
    ctrl.speed       = 2'd3;
    ctrl.drive_state = 3'd1;
    do_reset(1);
    exp_q = '{0, 2, 4, 6, 8, 10};
    for (int i = 0; i < 6; i++) measure_window("ramp_again");
    chk("full_pwm_on", 32'(ctrl.motor_l_pwm), 32'd1);
    ctrl.drive_state = 3'd6;
    step();
    chk("inval_pwm", 32'({ctrl.motor_l_pwm, ctrl.motor_r_pwm}), 32'd0);
    chk("inval_dir", 32'({ctrl.motor_l_in1, ctrl.motor_l_in2, ctrl.motor_r_in1, ctrl.motor_r_in2}), 32'd0);
    chk("inval_state_l", 32'(ctrl.state_l), 32'd0);

    // Restart from 0, reach 10, then ramp down to speed 1.
    ctrl.drive_state = 3'd1;
    exp_q = '{2, 4, 6, 8, 10};
    for (int i = 0; i < 5; i++) measure_window("restart");
    ctrl.speed = 2'd1;
    exp_q = '{10, 8, 6, 4, 4};
    for (int i = 0; i < 5; i++) measure_window("ramp_down");

    // enable=0 at the start of a period where pwm would be high.
    ctrl.enable = 1'b0;
    step();
    chk("dis_pwm", 32'(ctrl.motor_l_pwm), 32'd0);
    chk("dis_in1", 32'(ctrl.motor_l_in1), 32'd0);
    chk("dis_state_l", 32'(ctrl.state_l), 32'd0);
    ctrl.enable = 1'b1;

    // STOP during DEAD: countdown completes, then IDLE.
    ctrl.drive_state = 3'd1;
    do_reset(1);
    repeat (12) step();
    ctrl.drive_state = 3'd2;
    step();
    chk("dstop_braking", 32'(ctrl.braking), 32'd1);
    repeat (4) step();
    ctrl.drive_state = 3'd0;
    count_braking(DC - 5, "dstop_dead_len");
    step();
    chk("dstop_end_braking", 32'(ctrl.braking), 32'd0);
    chk("dstop_dir", 32'({ctrl.motor_l_in1, ctrl.motor_l_in2}), 32'd0);
    chk("dstop_state_l", 32'(ctrl.state_l), 32'd0);
    repeat (5) step();
    chk("dstop_stay_idle", 32'(ctrl.state_l), 32'd0);

    // Reset during DEAD clears braking in one cycle.
    ctrl.drive_state = 3'd1;
    repeat (3) step();
    ctrl.drive_state = 3'd2;
    repeat (3) step();
    chk("rdead_braking", 32'(ctrl.braking), 32'd1);
    reset = 1'b1;
    step();
    chk("rdead_cleared", 32'(ctrl.braking), 32'd0);
    chk("rdead_outputs", 32'(all_out()), 32'd0);
    reset = 1'b0;
    ctrl.drive_state = 3'd0;
    step();

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
